// File: rtl/eco32_core_ifu_way_cfx_pkg.sv
// Shared encodings for the instruction-cache way constant former:
// field-select codes, opcode constants and the prefix FSM state type.
package eco32_core_ifu_cfx_pkg;

  // Low field (13 bits) selects
  typedef enum logic [1:0] {
    LX_Z    = 2'd0,
    LX_LO13 = 2'd1,
    LX_A11  = 2'd2,
    LX_A10  = 2'd3
  } lsel_e;

  // Middle field (6 bits) selects
  typedef enum logic [1:0] {
    MX_Z  = 2'd0,
    MX_MI = 2'd1,
    MX_LS = 2'd2
  } msel_e;

  // High field (DW-19 bits) selects
  typedef enum logic [2:0] {
    HX_Z  = 3'd0,
    HX_LS = 3'd1,
    HX_MS = 3'd2,
    HX_S6 = 3'd3,
    HX_U6 = 3'd4,
    HX_HL = 3'd5
  } hsel_e;

  typedef struct packed {
    hsel_e h;
    msel_e m;
    lsel_e l;
  } sel_t;

  typedef enum logic {
    PFX_IDLE  = 1'b0,
    PFX_ARMED = 1'b1
  } pfx_state_e;

  localparam logic [5:0] OP_PFX = 6'h3A;
  localparam int         LW     = 13;
  localparam int         MW     = 6;

  localparam sel_t SEL_ZERO = '{h: HX_Z, m: MX_Z, l: LX_Z};

endpackage

// File: rtl/eco32_core_ifu_way_cfx_if.sv
// Beat interface between the way data RAM read side and the IFU output
// register. The constant former is the slave; the surrounding IFU is master.
interface eco32_core_ifu_way_cfx_if #(
  parameter int DW = 32,
  parameter int TW = 8
);
  logic          i_flush;
  logic          i_stb;
  logic          o_rdy;
  logic [31:0]   i_ins;
  logic          i_p0;
  logic [TW-1:0] i_tag;
  logic          o_stb;
  logic          i_rdy;
  logic [31:0]   o_ins;
  logic [TW-1:0] o_tag;
  logic [DW-1:0] o_cst;
  logic          o_pfx;
  logic          o_ext;

  modport slave (
    input  i_flush, i_stb, i_ins, i_p0, i_tag, i_rdy,
    output o_rdy, o_stb, o_ins, o_tag, o_cst, o_pfx, o_ext
  );

  modport master (
    output i_flush, i_stb, i_ins, i_p0, i_tag, i_rdy,
    input  o_rdy, o_stb, o_ins, o_tag, o_cst, o_pfx, o_ext
  );
endinterface

// File: rtl/eco32_core_ifu_way_cfx_dec.sv
// Combinational select decoder: {mopc, m, p0} -> {H, M, L} field selects.
// The prefix opcode is not special here; it falls to the all-zero default.
module eco32_core_ifu_cfx_dec
  import eco32_core_ifu_cfx_pkg::*;
(
  input  logic [5:0] mopc,
  input  logic       m,
  input  logic       p0,
  output sel_t       sel
);

  // Opcode table lookup, zero constant for anything unlisted
  always_comb begin
    sel = SEL_ZERO;
    case (mopc) inside
      [6'h00:6'h0F], [6'h20:6'h2B]: sel = '{h: HX_LS, m: MX_LS, l: LX_LO13};
      [6'h2C:6'h2F]:                sel = '{h: HX_LS, m: MX_LS, l: LX_A10};
      [6'h10:6'h13]:                sel = '{h: HX_HL, m: MX_Z,  l: LX_Z};
      6'h19:                        sel = '{h: HX_Z,  m: MX_Z,  l: LX_LO13};
      6'h33, 6'h36, 6'h37:          sel = '{h: HX_Z,  m: MX_Z,  l: LX_A10};
      6'h31, 6'h35:
        sel = p0 ? '{h: HX_Z,  m: MX_MI, l: LX_A11}
                 : '{h: HX_MS, m: MX_MI, l: LX_A11};
      6'h32:
        sel = p0 ? '{h: HX_Z,  m: MX_Z,  l: LX_A11}
                 : '{h: HX_LS, m: MX_LS, l: LX_A11};
      6'h34:
        sel = p0 ? '{h: HX_U6, m: MX_MI, l: LX_A11}
                 : '{h: HX_S6, m: MX_MI, l: LX_A11};
      6'h38, 6'h39:
        sel = m ? '{h: HX_HL, m: MX_MI, l: LX_Z}
                : '{h: HX_MS, m: MX_MI, l: LX_LO13};
      default:                      sel = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/eco32_core_ifu_way_cfx.sv
// Two-stage constant former for the instruction cache way.
// S1 holds the decoded selects, the raw instruction and the prefix outcome;
// S2 holds the assembled constant and the outgoing beat.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  PFX_IDLE  | no prefix pending; constants decode at native width
//  PFX_ARMED | prefix payload held; next non-prefix beat is widened
module eco32_core_ifu_way_cfx
  import eco32_core_ifu_cfx_pkg::*;
#(
  parameter int DW     = 32,
  parameter int TW     = 8,
  parameter bit PFX_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  eco32_core_ifu_way_cfx_if.slave bus
);

  localparam int HW = DW - LW - MW;

  logic          rdy_en;
  logic          s1_v;
  logic          s1_ld;
  logic          s2_ld;
  logic          accept;
  logic          pfx_op;
  sel_t          dec_sel;

  pfx_state_e    state_q, state_d;
  logic [25:0]   pay_q, pay_d;
  logic          beat_pfx;
  logic          beat_ext;

  logic [31:0]   s1_ins;
  logic [TW-1:0] s1_tag;
  sel_t          s1_sel;
  logic          s1_pfx;
  logic          s1_ext;
  logic [25:0]   s1_pay;

  logic [LW-1:0] l_fld;
  logic [MW-1:0] m_fld;
  logic [HW-1:0] h_fld;
  logic [DW-1:0] raw_cst;
  logic [DW-1:0] cst_d;
  logic [DW-LW-1:0] pay_ext;

  logic          o_stb_q;
  logic [31:0]   o_ins_q;
  logic [TW-1:0] o_tag_q;
  logic [DW-1:0] o_cst_q;
  logic          o_pfx_q;
  logic          o_ext_q;

  // Flow control: S2 advances when empty or drained, S1 when empty or S2 advances.
  // A beat offered alongside a flush is never taken.
  assign s2_ld  = ~o_stb_q | bus.i_rdy;
  assign s1_ld  = ~s1_v | s2_ld;
  assign accept = bus.i_stb & bus.o_rdy & ~bus.i_flush;
  assign pfx_op = PFX_EN && (bus.i_ins[31:26] == OP_PFX);

  eco32_core_ifu_cfx_dec u_dec (
    .mopc (bus.i_ins[31:26]),
    .m    (bus.i_ins[25]),
    .p0   (bus.i_p0),
    .sel  (dec_sel)
  );

  // Hold o_rdy low through reset and release it on the first clock after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Prefix FSM state and payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PFX_IDLE;
      pay_q   <= '0;
    end else if (bus.i_flush) begin
      state_q <= PFX_IDLE;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
    end
  end

  // Prefix FSM next state: only accepted beats move it; a repeated prefix restarts
  always_comb begin
    state_d  = state_q;
    pay_d    = pay_q;
    beat_pfx = 1'b0;
    beat_ext = 1'b0;
    if (accept) begin
      if (pfx_op) begin
        beat_pfx = 1'b1;
        pay_d    = bus.i_ins[25:0];
        state_d  = PFX_ARMED;
      end else if (state_q == PFX_ARMED) begin
        beat_ext = 1'b1;
        state_d  = PFX_IDLE;
      end
    end
  end

  // Stage 1: capture selects, instruction and prefix outcome of the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_ins <= '0;
      s1_tag <= '0;
      s1_sel <= SEL_ZERO;
      s1_pfx <= 1'b0;
      s1_ext <= 1'b0;
      s1_pay <= '0;
    end else begin
      if (bus.i_flush) s1_v <= 1'b0;
      else if (s1_ld)  s1_v <= accept;
      if (accept) begin
        s1_ins <= bus.i_ins;
        s1_tag <= bus.i_tag;
        s1_sel <= dec_sel;
        s1_pfx <= beat_pfx;
        s1_ext <= beat_ext;
        s1_pay <= pay_q;
      end
    end
  end

  // Field muxes driven by the stage-1 selects
  always_comb begin
    l_fld = '0;
    case (s1_sel.l)
      LX_LO13: l_fld = s1_ins[12:0];
      LX_A11:  l_fld = {2'b00, s1_ins[10:0]};
      LX_A10:  l_fld = {3'b000, s1_ins[9:0]};
      default: l_fld = '0;
    endcase

    m_fld = '0;
    case (s1_sel.m)
      MX_MI:   m_fld = s1_ins[18:13];
      MX_LS:   m_fld = {MW{s1_ins[12]}};
      default: m_fld = '0;
    endcase

    h_fld = '0;
    case (s1_sel.h)
      HX_LS:   h_fld = {HW{s1_ins[12]}};
      HX_MS:   h_fld = {HW{s1_ins[18]}};
      HX_S6:   h_fld = HW'($signed(s1_ins[24:19]));
      HX_U6:   h_fld = HW'(s1_ins[24:19]);
      HX_HL:   h_fld = HW'($signed(s1_ins[12:0]));
      default: h_fld = '0;
    endcase
  end

  // Widened beats keep the decoded low 13 bits under the sign-extended payload
  assign raw_cst = {h_fld, m_fld, l_fld};
  assign pay_ext = (DW-LW)'($signed(s1_pay));
  assign cst_d   = s1_pfx ? '0
                 : s1_ext ? {pay_ext, raw_cst[LW-1:0]}
                 : raw_cst;

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stb_q <= 1'b0;
      o_ins_q <= '0;
      o_tag_q <= '0;
      o_cst_q <= '0;
      o_pfx_q <= 1'b0;
      o_ext_q <= 1'b0;
    end else begin
      if (bus.i_flush) o_stb_q <= 1'b0;
      else if (s2_ld)  o_stb_q <= s1_v;
      if (s2_ld && s1_v && !bus.i_flush) begin
        o_ins_q <= s1_ins;
        o_tag_q <= s1_tag;
        o_cst_q <= cst_d;
        o_pfx_q <= s1_pfx;
        o_ext_q <= s1_ext;
      end
    end
  end

  assign bus.o_rdy = rdy_en & s1_ld;
  assign bus.o_stb = o_stb_q;
  assign bus.o_ins = o_ins_q;
  assign bus.o_tag = o_tag_q;
  assign bus.o_cst = o_cst_q;
  assign bus.o_pfx = o_pfx_q;
  assign bus.o_ext = o_ext_q;

endmodule

// File: tb/tb_eco32_core_ifu_way_cfx.sv
// Bench for the way constant former: directed scenarios plus a randomized
// stream, all checked against a scoreboard fed by a behavioural model.
module tb_eco32_core_ifu_way_cfx;
  localparam int DW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eco32_core_ifu_way_cfx_if #(.DW(DW), .TW(TW)) bus();

  eco32_core_ifu_way_cfx #(.DW(DW), .TW(TW), .PFX_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]   ins;
    logic [TW-1:0] tag;
    logic [DW-1:0] cst;
    logic          pfx;
    logic          ext;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  bit            m_armed = 1'b0;
  logic [25:0]   m_pay = '0;
  bit            last_acc = 1'b0;
  logic [DW-1:0] last_cst = '0;
  logic          last_ext = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_cst = '0;
  logic [31:0]   prev_ins = '0;
  logic [7:0]    tag_ctr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] build(input logic [63:0] h, input logic [63:0] mm,
                                        input logic [63:0] l);
    return (h << 19) | ((mm & 64'h3F) << 13) | (l & 64'h1FFF);
  endfunction

  // Constant value from the decode rules, using plain arithmetic on the fields
  function automatic logic [DW-1:0] ref_cst(input logic [31:0] ins, input logic p0);
    logic [5:0]  op;
    logic [63:0] ls, ms, s6, u6, hl, lo, a11, a10, mi, r;
    op  = ins[31:26];
    ls  = ins[12] ? '1 : '0;
    ms  = ins[18] ? '1 : '0;
    s6  = 64'($signed(ins[24:19]));
    u6  = 64'(ins[24:19]);
    hl  = 64'($signed(ins[12:0]));
    lo  = 64'(ins[12:0]);
    a11 = 64'(ins[10:0]);
    a10 = 64'(ins[9:0]);
    mi  = 64'(ins[18:13]);
    if (op <= 6'h0F || (op >= 6'h20 && op <= 6'h2B)) r = build(ls, ls, lo);
    else if (op >= 6'h2C && op <= 6'h2F)             r = build(ls, ls, a10);
    else if (op >= 6'h10 && op <= 6'h13)             r = build(hl, 0, 0);
    else if (op == 6'h19)                            r = build(0, 0, lo);
    else if (op == 6'h33 || op == 6'h36 || op == 6'h37) r = build(0, 0, a10);
    else if (op == 6'h31 || op == 6'h35) r = p0 ? build(0, mi, a11) : build(ms, mi, a11);
    else if (op == 6'h32) r = p0 ? build(0, 0, a11) : build(ls, ls, a11);
    else if (op == 6'h34) r = p0 ? build(u6, mi, a11) : build(s6, mi, a11);
    else if (op == 6'h38 || op == 6'h39) r = ins[25] ? build(hl, mi, 0) : build(ms, mi, lo);
    else r = '0;
    return r[DW-1:0];
  endfunction

  task automatic model_accept(input logic [31:0] ins, input logic p0, input logic [TW-1:0] tag);
    exp_t        e;
    logic [63:0] w;
    e.ins = ins;
    e.tag = tag;
    e.pfx = 1'b0;
    e.ext = 1'b0;
    if (ins[31:26] == 6'h3A) begin
      e.cst   = '0;
      e.pfx   = 1'b1;
      m_armed = 1'b1;
      m_pay   = ins[25:0];
    end else begin
      e.cst = ref_cst(ins, p0);
      if (m_armed) begin
        w       = (64'($signed(m_pay)) << 13) | (64'(e.cst) & 64'h1FFF);
        e.cst   = w[DW-1:0];
        e.ext   = 1'b1;
        m_armed = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, score, then return just after the rising edge
  task automatic step();
    bit   fire;
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_stb", 64'(bus.o_stb), 64'd1);
      chk("stall_cst", 64'(bus.o_cst), 64'(prev_cst));
      chk("stall_ins", 64'(bus.o_ins), 64'(prev_ins));
    end
    last_acc = bus.i_stb & bus.o_rdy & ~bus.i_flush;
    fire     = bus.o_stb & bus.i_rdy;
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("o_ins", 64'(bus.o_ins), 64'(e.ins));
        chk("o_tag", 64'(bus.o_tag), 64'(e.tag));
        chk("o_cst", 64'(bus.o_cst), 64'(e.cst));
        chk("o_pfx", 64'(bus.o_pfx), 64'(e.pfx));
        chk("o_ext", 64'(bus.o_ext), 64'(e.ext));
        last_cst = bus.o_cst;
        last_ext = bus.o_ext;
      end
    end
    prev_stall = bus.o_stb & ~bus.i_rdy & ~bus.i_flush;
    prev_cst   = bus.o_cst;
    prev_ins   = bus.o_ins;
    if (bus.i_flush) begin
      exp_q.delete();
      m_armed = 1'b0;
    end else if (last_acc) begin
      model_accept(bus.i_ins, bus.i_p0, bus.i_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic p0);
    int k;
    k = 0;
    bus.i_stb = 1'b1;
    bus.i_ins = ins;
    bus.i_p0  = p0;
    bus.i_tag = tag_ctr;
    tag_ctr++;
    do begin
      step();
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    bus.i_stb = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.i_stb   = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_rdy   = 1'b1;
    while ((exp_q.size() != 0 || bus.o_stb) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] t5_beats[4];
  int          t5_idx;

  initial begin
    bus.i_flush = 1'b0;
    bus.i_stb   = 1'b0;
    bus.i_ins   = '0;
    bus.i_p0    = 1'b0;
    bus.i_tag   = '0;
    bus.i_rdy   = 1'b1;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_stb", 64'(bus.o_stb), 64'd0);
    chk("rst_o_rdy", 64'(bus.o_rdy), 64'd0);
    chk("rst_o_cst", 64'(bus.o_cst), 64'd0);
    chk("rst_o_ins", 64'(bus.o_ins), 64'd0);
    chk("rst_o_tag", 64'(bus.o_tag), 64'd0);
    chk("rst_o_pfx", 64'(bus.o_pfx), 64'd0);
    chk("rst_o_ext", 64'(bus.o_ext), 64'd0);
    rst = 1'b0;
    #1;
    chk("rdy_before_clk", 64'(bus.o_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_clk", 64'(bus.o_rdy), 64'd1);

    // T1: all-ones sign extension, two-cycle latency
    send({6'h00, 13'h0, 13'h1FFF}, 1'b0);
    chk("t1_lat1_stb", 64'(bus.o_stb), 64'd0);
    step();
    chk("t1_lat2_stb", 64'(bus.o_stb), 64'd1);
    chk("t1_cst", 64'(bus.o_cst), 64'hFFFF_FFFF);
    drain();

    // T2: 0x34 with signed and unsigned x6
    send({6'h34, 1'b0, 6'h20, 6'h03, 13'h07FF}, 1'b0);
    drain();
    chk("t2_p0_0", 64'(last_cst), 64'hFF00_67FF);
    send({6'h34, 1'b0, 6'h20, 6'h03, 13'h07FF}, 1'b1);
    drain();
    chk("t2_p0_1", 64'(last_cst), 64'h0100_67FF);

    // T3: prefix then widened constant
    send({6'h3A, 26'h0012345}, 1'b0);
    send({6'h00, 13'h0, 13'h00AB}, 1'b0);
    drain();
    chk("t3_cst", 64'(last_cst), 64'h2468_A0AB);
    chk("t3_ext", 64'(last_ext), 64'd1);

    // T4: back-to-back prefixes, the second wins
    send({6'h3A, 26'h1}, 1'b0);
    send({6'h3A, 26'h2}, 1'b0);
    send({6'h10, 7'h0, 6'h0, 13'd5}, 1'b0);
    drain();
    chk("t4_cst", 64'(last_cst), 64'h0000_4000);
    chk("t4_ext", 64'(last_ext), 64'd1);

    // T5: downstream stall with four beats offered
    t5_beats[0] = {6'h19, 13'h0, 13'h0111};
    t5_beats[1] = {6'h33, 13'h0, 13'h0222};
    t5_beats[2] = {6'h2C, 13'h0, 13'h1333};
    t5_beats[3] = {6'h05, 13'h0, 13'h0444};
    t5_idx = 0;
    bus.i_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.i_stb = 1'b1;
      bus.i_ins = t5_beats[t5_idx];
      bus.i_p0  = 1'b0;
      bus.i_tag = tag_ctr;
      step();
      if (last_acc) begin
        t5_idx++;
        tag_ctr++;
      end
    end
    chk("t5_accepted", 64'(t5_idx), 64'd2);
    chk("t5_rdy_low", 64'(bus.o_rdy), 64'd0);
    bus.i_stb = 1'b0;
    bus.i_rdy = 1'b1;
    send(t5_beats[2], 1'b0);
    send(t5_beats[3], 1'b0);
    drain();

    // T6: flush while armed with both stages full
    bus.i_rdy = 1'b0;
    send({6'h3A, 26'h7}, 1'b0);
    send({6'h3A, 26'h8}, 1'b0);
    bus.i_flush = 1'b1;
    bus.i_stb   = 1'b1;
    bus.i_ins   = {6'h00, 13'h0, 13'h0777};
    step();
    bus.i_flush = 1'b0;
    bus.i_stb   = 1'b0;
    chk("t6_flush_stb", 64'(bus.o_stb), 64'd0);
    bus.i_rdy = 1'b1;
    send({6'h00, 13'h0, 13'h0012}, 1'b0);
    drain();
    chk("t6_ext", 64'(last_ext), 64'd0);
    chk("t6_cst", 64'(last_cst), 64'h0000_0012);

    // Reset mid-stream drops in-flight beats and the armed prefix
    bus.i_rdy = 1'b0;
    send({6'h3A, 26'h3FFFFFF}, 1'b0);
    send({6'h3A, 26'h5}, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_o_stb", 64'(bus.o_stb), 64'd0);
    chk("mrst_o_cst", 64'(bus.o_cst), 64'd0);
    chk("mrst_o_pfx", 64'(bus.o_pfx), 64'd0);
    chk("mrst_o_rdy", 64'(bus.o_rdy), 64'd0);
    exp_q.delete();
    m_armed    = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b1;
    send({6'h19, 13'h0, 13'h0055}, 1'b0);
    drain();
    chk("mrst_ext", 64'(last_ext), 64'd0);

    // Randomized stream with stalls, prefixes and occasional flushes
    for (int i = 0; i < 600; i++) begin
      bus.i_stb   = ($urandom_range(0, 3) != 0);
      bus.i_ins   = {(($urandom_range(0, 5) == 0) ? 6'h3A : 6'($urandom_range(0, 63))),
                     26'($urandom)};
      bus.i_p0    = 1'($urandom_range(0, 1));
      bus.i_tag   = TW'($urandom);
      bus.i_rdy   = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 39) == 0);
      step();
    end
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
